ghadi_display_scan: RTL and testbench
=====================================

GHADI_DISPLAY_SCAN -- requirements
Module: ghadi_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4: Ghadi cycles each digit is held (2..65535).
REQ-002 SHALL have parameter BLINK_DIV, default 8: scan frames per blink half-period while Alarm=1 (1..255).
REQ-003 SHALL have port Ghadi  in  1  sole clock, rising edge.
REQ-004 SHALL have port Reset_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port Hours_Ki_Tenth_digit_IN  in  2  hours tens BCD, zero-extended to 4 bits internally.
REQ-006 SHALL have ports Hours_Ki_Ones_digit_IN, Mins_Ki_Tenth_digit_IN, Mins_Ki_Ones_digit_IN, Secs_Ki_Tenth_digit_IN, Secs_Ki_Ones_digit_IN  in  4 each  BCD digits from the clock core.
REQ-007 SHALL have port Alarm  in  1  alarm active, level.
REQ-008 SHALL have port Seg_OUT  out  7  segments {a,b,c,d,e,f,g}, active-high, registered.
REQ-009 SHALL have port Dp_OUT  out  1  separator dot, active-high, registered.
REQ-010 SHALL have port Digit_Sel_OUT  out  6  one-hot digit enable, bit i = index i, registered.
REQ-011 SHALL have port Frame_Done  out  1  one-cycle pulse per completed frame, registered.

Function
REQ-012 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; at terminal count the digit index SHALL advance 0..5, wrapping 5->0.
REQ-013 Index order SHALL be 0=hours tens, 1=hours ones, 2=mins tens, 3=mins ones, 4=secs tens, 5=secs ones.
REQ-014 On the advance into index 0, all six inputs SHALL be captured into a shadow register; a frame SHALL display only shadow values, so mid-frame input changes appear from the next frame.
REQ-015 Seg_OUT, Dp_OUT and Digit_Sel_OUT SHALL update together in the cycle after prescaler terminal count (one cycle latency) and hold SCAN_DIV cycles.
REQ-016 Decode SHALL be 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; values 10..15 SHALL show dash 0000001.
REQ-017 Dp_OUT SHALL be 1 at indices 1 and 3, else 0.
REQ-018 Frame_Done SHALL pulse 1 in the same cycle the outputs switch from index 5 to index 0.
REQ-019 While Alarm=1, a frame counter SHALL toggle blink phase every BLINK_DIV frames, starting in on-phase; in off-phase Seg_OUT=0 and Dp_OUT=0 while Digit_Sel_OUT keeps scanning.
REQ-020 While Alarm=0, frame counter SHALL be held 0 and phase forced on; deassertion SHALL restore display from the next output update.
REQ-021 Alarm rising mid-frame SHALL begin counting at the next frame boundary.

Reset
REQ-022 Reset_n=0 at a rising edge SHALL set Seg_OUT=0, Dp_OUT=0, Digit_Sel_OUT=0, Frame_Done=0, shadow=0, frame counter=0, phase=on, index=5, prescaler=SCAN_DIV-1.
REQ-023 First cycle after release SHALL advance to index 0 and capture the shadow; Frame_Done SHALL NOT pulse on that first advance.
REQ-024 Reset mid-scan SHALL abandon the frame; no partial state survives.

Configuration
REQ-025 With LEADING_ZERO_BLANK_EN defined, index 0 with shadow value 0 SHALL drive Seg_OUT=0 (Dp unaffected); without it, index 0 shows 1111110.

Structure
REQ-026 Package ghadi_pkg SHALL hold NUM_DIGITS=6, digit-index typedef (3 bits), segment typedef (7 bits), SEG_BLANK, SEG_DASH and the ten digit patterns.
REQ-027 Decode SHALL be sub-module ghadi_seg_decode (4-bit in, 7-bit out, combinational), instantiated once.

Verification (SCAN_DIV=4, BLINK_DIV=2)
REQ-028 Reset, inputs 12:34:56 -> Digit_Sel 000001..100000 each 4 cycles; Seg 0110000,1101101,1111001,0110011,1011011,1011111; Dp at indices 1,3; Frame_Done after frame 1 only at 5->0.
REQ-029 Inputs change 12:34:56 -> 12:35:00 while index 2 -> rest of frame shows 4,5,6; next frame shows 5,0,0.
REQ-030 Alarm=1 at frame boundary -> 2 frames lit, 2 frames Seg=0/Dp=0 with Digit_Sel scanning, repeat; Alarm=0 -> lit at next update.
REQ-031 Mins_Ki_Ones_digit_IN=4'hC -> index 3 Seg=0000001, Dp=1.
REQ-032 Reset_n=0 at index 3 -> next edge all outputs 0; release -> Digit_Sel=000001 one cycle later, no Frame_Done.
REQ-033 Hours 05, with and without LEADING_ZERO_BLANK_EN -> index 0 Seg=0000000 vs 1111110; index 1 Seg=1011011 both.

Source files
------------

// File: rtl/ghadi_pkg.sv
// Shared types and segment patterns for the Ghadi six-digit display scanner.
package ghadi_pkg;

    localparam int NUM_DIGITS = 6;

    typedef logic [2:0] digit_idx_t;
    typedef logic [6:0] seg_t;

    typedef enum logic {
        PH_OFF = 1'b0,
        PH_ON  = 1'b1
    } phase_e;

    localparam digit_idx_t FIRST_IDX = 3'd0;
    localparam digit_idx_t LAST_IDX  = 3'd5;

    // Segment order is {a,b,c,d,e,f,g}, active-high.
    localparam seg_t SEG_BLANK = 7'b0000000;
    localparam seg_t SEG_DASH  = 7'b0000001;
    localparam seg_t SEG_0     = 7'b1111110;
    localparam seg_t SEG_1     = 7'b0110000;
    localparam seg_t SEG_2     = 7'b1101101;
    localparam seg_t SEG_3     = 7'b1111001;
    localparam seg_t SEG_4     = 7'b0110011;
    localparam seg_t SEG_5     = 7'b1011011;
    localparam seg_t SEG_6     = 7'b1011111;
    localparam seg_t SEG_7     = 7'b1110000;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1111011;

    function automatic logic is_sep_idx(digit_idx_t idx);
        return (idx == 3'd1) || (idx == 3'd3);
    endfunction

endpackage

// File: rtl/ghadi_display_scan_if.sv
// Bundle of the clock-core digit bus and the scanned display outputs.
interface ghadi_display_scan_if;

    logic [1:0] hours_tens;
    logic [3:0] hours_ones;
    logic [3:0] mins_tens;
    logic [3:0] mins_ones;
    logic [3:0] secs_tens;
    logic [3:0] secs_ones;
    logic       alarm;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] digit_sel;
    logic       frame_done;

    modport master (
        output hours_tens, hours_ones, mins_tens, mins_ones,
        output secs_tens, secs_ones, alarm,
        input  seg, dp, digit_sel, frame_done
    );

    modport slave (
        input  hours_tens, hours_ones, mins_tens, mins_ones,
        input  secs_tens, secs_ones, alarm,
        output seg, dp, digit_sel, frame_done
    );

endinterface

// File: rtl/ghadi_seg_decode.sv
// BCD to seven-segment decoder; codes 10..15 render as a dash.
module ghadi_seg_decode
    import ghadi_pkg::*;
(
    input  logic [3:0] bcd_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/ghadi_display_scan.sv
// Multiplexed six-digit display scanner with frame shadowing and alarm blink.
// Optional LEADING_ZERO_BLANK_EN blanks a zero hours-tens digit.
module ghadi_display_scan
    import ghadi_pkg::*;
#(
    parameter int SCAN_DIV  = 4,
    parameter int BLINK_DIV = 8
) (
    input  logic       Ghadi,
    input  logic       Reset_n,
    input  logic [1:0] Hours_Ki_Tenth_digit_IN,
    input  logic [3:0] Hours_Ki_Ones_digit_IN,
    input  logic [3:0] Mins_Ki_Tenth_digit_IN,
    input  logic [3:0] Mins_Ki_Ones_digit_IN,
    input  logic [3:0] Secs_Ki_Tenth_digit_IN,
    input  logic [3:0] Secs_Ki_Ones_digit_IN,
    input  logic       Alarm,
    output logic [6:0] Seg_OUT,
    output logic       Dp_OUT,
    output logic [5:0] Digit_Sel_OUT,
    output logic       Frame_Done
);

    localparam logic [15:0] PRESC_TC = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  BLINK_TC = 8'(BLINK_DIV - 1);

    logic [15:0] presc_q, presc_d;
    digit_idx_t  idx_q, idx_d;
    logic [NUM_DIGITS-1:0][3:0] shad_q, shad_d;
    logic [7:0]  fcnt_q, fcnt_d;
    phase_e      phase_q, phase_d;
    logic        act_q, act_d;
    logic        started_q, started_d;
    seg_t        seg_q, seg_d;
    logic        dp_q, dp_d;
    logic [5:0]  sel_q, sel_d;
    logic        fd_q, fd_d;

    logic        adv;
    logic        wrap;
    logic [3:0]  digit;
    seg_t        dec_seg;

    ghadi_seg_decode u_dec (
        .bcd_i (digit),
        .seg_o (dec_seg)
    );

    assign adv   = (presc_q == PRESC_TC);
    assign wrap  = adv && (idx_q == LAST_IDX);
    assign digit = shad_d[idx_d];

    always_comb begin
        presc_d   = presc_q + 16'd1;
        idx_d     = idx_q;
        shad_d    = shad_q;
        fcnt_d    = fcnt_q;
        phase_d   = phase_q;
        act_d     = act_q;
        started_d = started_q;
        seg_d     = seg_q;
        dp_d      = dp_q;
        sel_d     = sel_q;
        fd_d      = 1'b0;

        if (adv) begin
            presc_d = '0;
            idx_d   = wrap ? FIRST_IDX : idx_q + 3'd1;
        end

        // Frame boundary: latch a coherent time and advance the blink count.
        if (wrap) begin
            shad_d = {Secs_Ki_Ones_digit_IN, Secs_Ki_Tenth_digit_IN,
                      Mins_Ki_Ones_digit_IN, Mins_Ki_Tenth_digit_IN,
                      Hours_Ki_Ones_digit_IN,
                      {2'b00, Hours_Ki_Tenth_digit_IN}};
            fd_d      = started_q;
            started_d = 1'b1;
            act_d     = Alarm;
            if (Alarm && act_q) begin
                if (fcnt_q == BLINK_TC) begin
                    fcnt_d  = '0;
                    phase_d = (phase_q == PH_ON) ? PH_OFF : PH_ON;
                end else begin
                    fcnt_d = fcnt_q + 8'd1;
                end
            end
        end

        if (!Alarm) begin
            fcnt_d  = '0;
            phase_d = PH_ON;
            act_d   = 1'b0;
        end

        if (adv) begin
            sel_d = 6'b000001 << idx_d;
            dp_d  = (phase_d == PH_ON) && is_sep_idx(idx_d);
            seg_d = (phase_d == PH_ON) ? dec_seg : SEG_BLANK;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx_d == FIRST_IDX && digit == 4'd0) begin
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    always_ff @(posedge Ghadi) begin
        if (!Reset_n) begin
            presc_q   <= PRESC_TC;
            idx_q     <= LAST_IDX;
            shad_q    <= '0;
            fcnt_q    <= '0;
            phase_q   <= PH_ON;
            act_q     <= 1'b0;
            started_q <= 1'b0;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b0;
            sel_q     <= '0;
            fd_q      <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shad_q    <= shad_d;
            fcnt_q    <= fcnt_d;
            phase_q   <= phase_d;
            act_q     <= act_d;
            started_q <= started_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            sel_q     <= sel_d;
            fd_q      <= fd_d;
        end
    end

    assign Seg_OUT       = seg_q;
    assign Dp_OUT        = dp_q;
    assign Digit_Sel_OUT = sel_q;
    assign Frame_Done    = fd_q;

endmodule

// File: tb/tb_ghadi_display_scan.sv
// Bench for ghadi_display_scan: directed scenarios then random traffic vs a frame-level model.
module tb_ghadi_display_scan;

    localparam int SD = 4;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ghadi_display_scan_if bus();

    always #5 clk = ~clk;

    ghadi_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .Ghadi                   (clk),
        .Reset_n                 (rst_n),
        .Hours_Ki_Tenth_digit_IN (bus.hours_tens),
        .Hours_Ki_Ones_digit_IN  (bus.hours_ones),
        .Mins_Ki_Tenth_digit_IN  (bus.mins_tens),
        .Mins_Ki_Ones_digit_IN   (bus.mins_ones),
        .Secs_Ki_Tenth_digit_IN  (bus.secs_tens),
        .Secs_Ki_Ones_digit_IN   (bus.secs_ones),
        .Alarm                   (bus.alarm),
        .Seg_OUT                 (bus.seg),
        .Dp_OUT                  (bus.dp),
        .Digit_Sel_OUT           (bus.digit_sel),
        .Frame_Done              (bus.frame_done)
    );

    int errs = 0;
    int checks = 0;

    // Reference model state: cycles since release, displayed digit, blink frames.
    int         m_cyc = 0;
    int         m_idx = 5;
    int         m_frames = 0;
    bit         m_started = 0;
    bit         m_act = 0;
    bit         m_lit = 1;
    bit         m_adv = 0;
    logic [3:0] m_sh [6];
    logic [6:0] e_seg = '0;
    logic       e_dp = 1'b0;
    logic [5:0] e_sel = '0;
    logic       e_fd = 1'b0;

    function automatic logic [6:0] ref_seg(logic [3:0] v);
        case (v)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
            default: return 7'b0000001;
        endcase
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        m_adv = 0;
        if (!rst_n) begin
            m_cyc = 0; m_idx = 5; m_frames = 0;
            m_started = 0; m_act = 0; m_lit = 1;
            for (int i = 0; i < 6; i++) m_sh[i] = 4'd0;
            e_seg = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
        end else begin
            e_fd = 1'b0;
            if (!bus.alarm) begin
                m_act = 0;
                m_frames = 0;
            end
            if (m_cyc % SD == 0) begin
                m_adv = 1;
                m_idx = (m_idx + 1) % 6;
                if (m_idx == 0) begin
                    m_sh = '{{2'b00, bus.hours_tens}, bus.hours_ones,
                             bus.mins_tens, bus.mins_ones,
                             bus.secs_tens, bus.secs_ones};
                    e_fd = m_started;
                    m_started = 1;
                    if (bus.alarm) begin
                        if (m_act) m_frames++;
                        m_act = 1;
                    end
                end
                m_lit = !bus.alarm || ((m_frames / BD) % 2 == 0);
                e_sel = 6'b000001 << m_idx;
                e_dp  = m_lit && (m_idx == 1 || m_idx == 3);
                e_seg = m_lit ? ref_seg(m_sh[m_idx]) : 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
                if (m_idx == 0 && m_sh[0] == 4'd0) e_seg = 7'b0000000;
`endif
            end
            m_cyc++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("seg", {1'b0, bus.seg}, {1'b0, e_seg});
        chk("dp", {7'b0, bus.dp}, {7'b0, e_dp});
        chk("sel", {2'b0, bus.digit_sel}, {2'b0, e_sel});
        chk("frame_done", {7'b0, bus.frame_done}, {7'b0, e_fd});
    endtask

    task automatic run_to(int target);
        bit hit = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (m_adv && m_idx == target) begin
                hit = 1;
                break;
            end
        end
        checks++;
        assert (hit) else begin
            errs++;
            $error("FAIL run_to: index %0d not reached, observed sel %b", target, bus.digit_sel);
        end
    endtask

    task automatic set_time(int ht, int ho, int mt, int mo, int st, int so);
        bus.hours_tens = 2'(ht);
        bus.hours_ones = 4'(ho);
        bus.mins_tens  = 4'(mt);
        bus.mins_ones  = 4'(mo);
        bus.secs_tens  = 4'(st);
        bus.secs_ones  = 4'(so);
    endtask

    initial begin
        bus.alarm = 1'b0;
        set_time(1, 2, 3, 4, 5, 6);
        rst_n = 1'b0;
        step();
        step();
        chk("rst_sel", {2'b0, bus.digit_sel}, 8'h00);
        chk("rst_seg", {1'b0, bus.seg}, 8'h00);

        rst_n = 1'b1;
        step();
        chk("first_sel", {2'b0, bus.digit_sel}, 8'b0000_0001);
        chk("first_seg", {1'b0, bus.seg}, 8'b0011_0000);
        chk("first_fd", {7'b0, bus.frame_done}, 8'h00);
        for (int i = 0; i < 24; i++) step();
        chk("wrap_fd", {7'b0, bus.frame_done}, 8'h01);

        run_to(2);
        set_time(1, 2, 3, 5, 0, 0);
        run_to(3);
        chk("old_min", {1'b0, bus.seg}, 8'b0011_0011);
        run_to(0);
        run_to(3);
        chk("new_min", {1'b0, bus.seg}, 8'b0101_1011);
        run_to(4);
        chk("new_sec", {1'b0, bus.seg}, 8'b0111_1110);

        bus.mins_ones = 4'hC;
        run_to(0);
        run_to(3);
        chk("dash_seg", {1'b0, bus.seg}, 8'b0000_0001);
        chk("dash_dp", {7'b0, bus.dp}, 8'h01);

        set_time(0, 5, 3, 4, 5, 6);
        run_to(0);
`ifdef LEADING_ZERO_BLANK_EN
        chk("lz_seg", {1'b0, bus.seg}, 8'h00);
`else
        chk("lz_seg", {1'b0, bus.seg}, 8'b0111_1110);
`endif
        run_to(1);
        chk("h_ones", {1'b0, bus.seg}, 8'b0101_1011);

        run_to(3);
        bus.alarm = 1'b1;
        run_to(0);
        run_to(1);
        chk("blink_a", {1'b0, bus.seg}, 8'b0101_1011);
        run_to(0);
        run_to(1);
        chk("blink_b", {1'b0, bus.seg}, 8'b0101_1011);
        run_to(0);
        run_to(1);
        chk("blink_off_seg", {1'b0, bus.seg}, 8'h00);
        chk("blink_off_dp", {7'b0, bus.dp}, 8'h00);
        chk("blink_off_sel", {2'b0, bus.digit_sel}, 8'b0000_0010);
        bus.alarm = 1'b0;
        run_to(2);
        chk("restore_seg", {1'b0, bus.seg}, 8'b0111_1001);
        run_to(3);
        chk("restore_dp", {7'b0, bus.dp}, 8'h01);

        rst_n = 1'b0;
        step();
        chk("mid_rst_sel", {2'b0, bus.digit_sel}, 8'h00);
        chk("mid_rst_seg", {1'b0, bus.seg}, 8'h00);
        rst_n = 1'b1;
        step();
        chk("rel_sel", {2'b0, bus.digit_sel}, 8'b0000_0001);
        chk("rel_fd", {7'b0, bus.frame_done}, 8'h00);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 5))
                    0: bus.hours_tens = 2'($urandom_range(0, 3));
                    1: bus.hours_ones = 4'($urandom_range(0, 15));
                    2: bus.mins_tens  = 4'($urandom_range(0, 15));
                    3: bus.mins_ones  = 4'($urandom_range(0, 15));
                    4: bus.secs_tens  = 4'($urandom_range(0, 15));
                    default: bus.secs_ones = 4'($urandom_range(0, 15));
                endcase
            end
            if ($urandom_range(0, 149) == 0) bus.alarm = ~bus.alarm;
            rst_n = ($urandom_range(0, 399) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
